// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared RS(255,251) constants, sequencer state encoding and helpers
// Used by rs_block_sequencer, rs_encoder and their benches.
package rs_pkg;

  localparam int NN        = 255;
  localparam int KK        = 251;
  localparam int TT        = 2;
  localparam int BLK_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    WAIT = 2'd3
  } rs_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_block_sequencer.sv
// rtl/rs_block_sequencer.sv - cuts a byte stream into KK-byte RS message blocks for rs_encoder
// Zero-pads a partial block on flush and holds the next block until the codeword is out.
module rs_block_sequencer #(
  parameter int NN    = rs_pkg::NN,
  parameter int KK    = rs_pkg::KK,
  parameter int BLK_W = rs_pkg::BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             flush,
  output logic             enc_din_val,
  output logic             enc_din_sop,
  output logic             enc_din_eop,
  output logic [7:0]       enc_din,
  input  logic             enc_busy,
  input  logic             enc_dout_eop,
  output logic [BLK_W-1:0] blk_done_cnt,
  output logic [7:0]       last_pad_len,
  output logic             active
);
  import rs_pkg::*;

  localparam int            CW      = clog2(KK + 1);
  localparam logic [CW-1:0] KK_CW   = CW'(KK);
  localparam logic [CW-1:0] KK_LAST = CW'(KK - 1);

  if (KK >= NN || KK < 2) begin : g_param_check
    $error("rs_block_sequencer: KK must satisfy 2 <= KK < NN");
  end

  rs_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pad_len;
  logic          w_s_ready;
  logic          w_accept;
  logic          w_last_byte;

  // Ready depends on state only so upstream never sees a combinational path from flush.
  assign w_s_ready   = !rst && (((r_state == IDLE) && !enc_busy) || (r_state == DATA));
  assign w_accept    = s_valid && w_s_ready;
  assign w_last_byte = (r_cnt == KK_LAST);
  assign s_ready     = w_s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pad_len    <= '0;
      enc_din_val  <= 1'b0;
      enc_din_sop  <= 1'b0;
      enc_din_eop  <= 1'b0;
      enc_din      <= '0;
      blk_done_cnt <= '0;
      last_pad_len <= '0;
      active       <= 1'b0;
    end else begin
      enc_din_val <= 1'b0;
      enc_din_sop <= 1'b0;
      enc_din_eop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            enc_din_val <= 1'b1;
            enc_din_sop <= 1'b1;
            enc_din     <= s_data;
            r_cnt       <= CW'(1);
            r_state     <= DATA;
            active      <= 1'b1;
          end
        end
        DATA: begin
          if (w_accept) begin
            enc_din_val <= 1'b1;
            enc_din     <= s_data;
            r_cnt       <= r_cnt + CW'(1);
            // A byte that completes the block swallows a coincident flush.
            if (w_last_byte) begin
              enc_din_eop  <= 1'b1;
              last_pad_len <= '0;
              r_state      <= WAIT;
            end else if (flush) begin
              r_pad_len <= 8'(KK_CW - r_cnt - CW'(1));
              r_state   <= PAD;
            end
          end else if (flush) begin
            r_pad_len <= 8'(KK_CW - r_cnt);
            r_state   <= PAD;
          end
        end
        PAD: begin
          enc_din_val <= 1'b1;
          enc_din     <= '0;
          r_cnt       <= r_cnt + CW'(1);
          if (w_last_byte) begin
            enc_din_eop  <= 1'b1;
            last_pad_len <= r_pad_len;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (enc_dout_eop) begin
            blk_done_cnt <= blk_done_cnt + BLK_W'(1);
            r_cnt        <= '0;
            r_state      <= IDLE;
            active       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_block_sequencer.sv
// tb/tb_rs_block_sequencer.sv - directed bench for rs_block_sequencer with an rs_encoder latency model
// Table-driven first cycles, then multi-cycle block sequences checked from a byte log.
module tb_rs_block_sequencer;
  import rs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       flush;
  logic       enc_din_val;
  logic       enc_din_sop;
  logic       enc_din_eop;
  logic [7:0] enc_din;
  logic       enc_busy;
  logic       enc_dout_eop;
  logic [3:0] blk_done_cnt;
  logic [7:0] last_pad_len;
  logic       active;

  always #5 clk = ~clk;

  rs_block_sequencer #(.BLK_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .flush        (flush),
    .enc_din_val  (enc_din_val),
    .enc_din_sop  (enc_din_sop),
    .enc_din_eop  (enc_din_eop),
    .enc_din      (enc_din),
    .enc_busy     (enc_busy),
    .enc_dout_eop (enc_dout_eop),
    .blk_done_cnt (blk_done_cnt),
    .last_pad_len (last_pad_len),
    .active       (active)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // encoder model: dout_eop NN-KK cycles after din_eop is seen
  bit model_en = 1'b0;
  int lat = 0;
  always @(posedge clk) begin
    #2;
    if (model_en) begin
      enc_dout_eop = 1'b0;
      if (enc_din_eop) begin
        enc_busy = 1'b1;
        lat = NN - KK;
      end else if (lat != 0) begin
        lat = lat - 1;
        if (lat == 0) enc_dout_eop = 1'b1;
      end else begin
        enc_busy = 1'b0;
      end
    end
  end

  // output log
  bit mon_en = 1'b0;
  bit gap_chk = 1'b0;
  bit in_wait = 1'b0;
  bit prev_acc = 1'b0;
  int vq[$];
  int sop_idx[$];
  int eop_idx[$];
  int n_acc, wait_acc, gap_err, cyc, first_acc, first_sop;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gap_chk && (enc_din_val !== prev_acc)) gap_err++;
      prev_acc = s_valid && s_ready;
      if (prev_acc) begin
        n_acc++;
        if (in_wait) wait_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (enc_din_val) begin
        vq.push_back(int'(enc_din));
        if (enc_din_sop) begin
          sop_idx.push_back(vq.size() - 1);
          if (first_sop < 0) first_sop = cyc;
        end
        if (enc_din_eop) eop_idx.push_back(vq.size() - 1);
      end
      if (enc_din_eop) in_wait = 1'b1;
      if (enc_dout_eop) in_wait = 1'b0;
    end
  end

  task automatic clear_log();
    vq.delete();
    sop_idx.delete();
    eop_idx.delete();
    n_acc = 0; wait_acc = 0; gap_err = 0;
    in_wait = 1'b0; prev_acc = 1'b0;
    first_acc = -1; first_sop = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; flush = 1'b0;
    enc_busy = 1'b0; enc_dout_eop = 1'b0; lat = 0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit fl);
    bit done;
    int t;
    done = 1'b0; t = 0;
    s_valid = 1'b1; s_data = d; flush = fl;
    while (!done && t < 2000) begin
      @(negedge clk);
      done = s_ready;
      tick();
      flush = 1'b0;
      t++;
    end
    s_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    s_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (active && t < 3000) begin
      tick();
      t++;
    end
    if (active) chk("idle_timeout", 0, 1);
    tick();
  endtask

  typedef struct {
    int vld; int d; int fl; int busy; int deop;
    int e_rdy; int e_val; int e_sop; int e_eop; int e_din; int e_act; int e_blk;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pads, zero_err, got_eop, t, errs;

    //          vld  d     fl busy deop  rdy val sop eop din   act blk
    tbl[0] = '{1, 'hAA, 0, 1, 0,    0, 0, 0, 0, 'h00, 0, 0};
    tbl[1] = '{0, 'h00, 1, 0, 0,    1, 0, 0, 0, 'h00, 0, 0};
    tbl[2] = '{0, 'h00, 0, 0, 1,    1, 0, 0, 0, 'h00, 0, 0};
    tbl[3] = '{1, 'h11, 0, 0, 0,    1, 0, 0, 0, 'h00, 0, 0};
    tbl[4] = '{0, 'h00, 0, 0, 0,    1, 1, 1, 0, 'h11, 1, 0};
    tbl[5] = '{1, 'h22, 0, 0, 0,    1, 0, 0, 0, 'h00, 1, 0};
    tbl[6] = '{0, 'h00, 0, 0, 1,    1, 1, 0, 0, 'h22, 1, 0};
    tbl[7] = '{0, 'h00, 1, 0, 0,    1, 0, 0, 0, 'h00, 1, 0};
    tbl[8] = '{1, 'h33, 0, 0, 0,    0, 0, 0, 0, 'h00, 1, 0};
    tbl[9] = '{0, 'h00, 0, 0, 0,    0, 1, 0, 0, 'h00, 1, 0};

    clear_log();
    do_reset();
    @(negedge clk);
    chk("rst_val", int'(enc_din_val), 0);
    chk("rst_sop", int'(enc_din_sop), 0);
    chk("rst_eop", int'(enc_din_eop), 0);
    chk("rst_din", int'(enc_din), 0);
    chk("rst_blk", int'(blk_done_cnt), 0);
    chk("rst_pad", int'(last_pad_len), 0);
    chk("rst_act", int'(active), 0);

    for (int i = 0; i < 10; i++) begin
      tick();
      s_valid = tbl[i].vld[0]; s_data = tbl[i].d[7:0]; flush = tbl[i].fl[0];
      enc_busy = tbl[i].busy[0]; enc_dout_eop = tbl[i].deop[0];
      @(negedge clk);
      chk($sformatf("row%0d_rdy", i), int'(s_ready), tbl[i].e_rdy);
      chk($sformatf("row%0d_val", i), int'(enc_din_val), tbl[i].e_val);
      chk($sformatf("row%0d_sop", i), int'(enc_din_sop), tbl[i].e_sop);
      chk($sformatf("row%0d_eop", i), int'(enc_din_eop), tbl[i].e_eop);
      if (tbl[i].e_val != 0) chk($sformatf("row%0d_din", i), int'(enc_din), tbl[i].e_din);
      chk($sformatf("row%0d_act", i), int'(active), tbl[i].e_act);
      chk($sformatf("row%0d_blk", i), int'(blk_done_cnt), tbl[i].e_blk);
    end

    // rest of the padding started by row 7: 249 zero bytes in total
    pads = 1; zero_err = 0; got_eop = 0; t = 0;
    while (got_eop == 0 && t < 400) begin
      tick();
      s_valid = 1'b0; flush = 1'b0; enc_dout_eop = 1'b0;
      @(negedge clk);
      if (enc_din_val) begin
        pads++;
        if (enc_din != 8'h00) zero_err++;
        if (enc_din_eop) got_eop = 1;
      end
      t++;
    end
    chk("tbl_pad_eop", got_eop, 1);
    chk("tbl_pad_count", pads, 249);
    chk("tbl_pad_zero", zero_err, 0);
    chk("tbl_last_pad", int'(last_pad_len), 249);
    chk("tbl_wait_rdy", int'(s_ready), 0);
    repeat (3) tick();
    @(negedge clk);
    chk("tbl_wait_hold", int'(active), 1);
    chk("tbl_wait_noval", int'(enc_din_val), 0);
    tick();
    enc_dout_eop = 1'b1;
    tick();
    enc_dout_eop = 1'b0;
    chk("tbl_blk", int'(blk_done_cnt), 1);
    chk("tbl_idle", int'(active), 0);

    // continuous stream: 0x01..0xFB then 0x01
    model_en = 1'b1;
    do_reset();
    clear_log();
    mon_en = 1'b1;
    for (int k = 0; k < 252; k++) send_byte((k < 251) ? 8'(k + 1) : 8'h01, 1'b0);
    repeat (2) tick();
    chk("a_sop_latency", first_sop - first_acc, 1);
    chk("a_first_byte", qat(vq, 0), 1);
    chk("a_sop0", qat(sop_idx, 0), 0);
    chk("a_eop_count", eop_idx.size(), 1);
    chk("a_eop0", qat(eop_idx, 0), 250);
    chk("a_eop_byte", qat(vq, 250), 251);
    chk("a_wait_accepts", wait_acc, 0);
    chk("a_sop1", qat(sop_idx, 1), 251);
    chk("a_sop1_byte", qat(vq, 251), 1);
    chk("a_blk", int'(blk_done_cnt), 1);

    // partial block of 10 bytes then flush
    do_reset();
    clear_log();
    for (int k = 0; k < 10; k++) send_byte(8'(8'hA0 + k), 1'b0);
    pulse_flush();
    wait_idle();
    errs = 0;
    for (int k = 0; k < 10; k++) if (qat(vq, k) != 'hA0 + k) errs++;
    for (int k = 10; k < 251; k++) if (qat(vq, k) != 0) errs++;
    chk("b_val_count", vq.size(), 251);
    chk("b_bytes", errs, 0);
    chk("b_sop_count", sop_idx.size(), 1);
    chk("b_eop0", qat(eop_idx, 0), 250);
    chk("b_last_pad", int'(last_pad_len), 241);
    chk("b_blk", int'(blk_done_cnt), 1);

    // flush together with the block-completing byte
    clear_log();
    for (int k = 0; k < 250; k++) send_byte(8'(k), 1'b0);
    send_byte(8'h5A, 1'b1);
    wait_idle();
    repeat (5) tick();
    chk("c_val_count", vq.size(), 251);
    chk("c_eop0", qat(eop_idx, 0), 250);
    chk("c_eop_byte", qat(vq, 250), 'h5A);
    chk("c_last_pad", int'(last_pad_len), 0);
    chk("c_blk", int'(blk_done_cnt), 2);

    // flush together with byte 5
    clear_log();
    for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 1'b0);
    send_byte(8'hC5, 1'b1);
    wait_idle();
    chk("d_val_count", vq.size(), 251);
    chk("d_byte5", qat(vq, 4), 'hC5);
    chk("d_eop0", qat(eop_idx, 0), 250);
    chk("d_last_pad", int'(last_pad_len), 246);
    chk("d_blk", int'(blk_done_cnt), 3);

    // gappy input 1,0,0,...
    clear_log();
    gap_chk = 1'b1;
    t = 0;
    while (n_acc < 251 && t < 2000) begin
      s_valid = (t % 3 == 0);
      s_data = 8'(n_acc + 1);
      tick();
      t++;
    end
    s_valid = 1'b0;
    wait_idle();
    gap_chk = 1'b0;
    errs = 0;
    for (int k = 0; k < 251; k++) if (qat(vq, k) != k + 1) errs++;
    chk("e_gap_align", gap_err, 0);
    chk("e_val_count", vq.size(), 251);
    chk("e_bytes", errs, 0);
    chk("e_sop_count", sop_idx.size(), 1);
    chk("e_sop0", qat(sop_idx, 0), 0);
    chk("e_eop0", qat(eop_idx, 0), 250);
    chk("e_blk", int'(blk_done_cnt), 4);

    // flush in IDLE, then reset in the middle of a block
    clear_log();
    pulse_flush();
    repeat (5) tick();
    chk("f_idle_flush_vals", vq.size(), 0);
    chk("f_idle_flush_act", int'(active), 0);
    for (int k = 0; k < 99; k++) send_byte(8'(k + 1), 1'b0);
    s_valid = 1'b1; s_data = 8'h64; rst = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    chk("f_rst_val", int'(enc_din_val), 0);
    chk("f_rst_sop", int'(enc_din_sop), 0);
    chk("f_rst_eop", int'(enc_din_eop), 0);
    chk("f_rst_din", int'(enc_din), 0);
    chk("f_rst_act", int'(active), 0);
    chk("f_rst_blk", int'(blk_done_cnt), 0);
    chk("f_rst_vals", vq.size(), 99);
    chk("f_rst_no_eop", eop_idx.size(), 0);
    clear_log();
    send_byte(8'h77, 1'b0);
    repeat (2) tick();
    chk("f_new_sop", qat(sop_idx, 0), 0);
    chk("f_new_byte", qat(vq, 0), 'h77);
    pulse_flush();
    wait_idle();
    chk("f_blk", int'(blk_done_cnt), 1);

    // 16 single-byte blocks wrap the 4-bit counter
    do_reset();
    clear_log();
    for (int b = 0; b < 16; b++) begin
      send_byte(8'(b + 1), 1'b0);
      pulse_flush();
      wait_idle();
      if (b == 0) begin
        chk("g_val_count", vq.size(), 251);
        chk("g_sop0", qat(sop_idx, 0), 0);
        chk("g_eop0", qat(eop_idx, 0), 250);
        chk("g_last_pad", int'(last_pad_len), 250);
      end
      if (b == 14) chk("g_blk15", int'(blk_done_cnt), 15);
    end
    chk("g_blk_wrap", int'(blk_done_cnt), 0);
    chk("g_sop_total", sop_idx.size(), 16);
    chk("g_eop_total", eop_idx.size(), 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
